// File: rtl/sim_video_out.sv
// Video output stage for the simulation top: pixel clock-enable, colour expansion/blanking and
// line/frame geometry measurement. Define SIM_VIDEO_STATS_EN to build the geometry/frame statistics.
module sim_video_out #(
  parameter int IN_W   = 6,
  parameter int CE_DIV = 4,
  parameter int HCNT_W = 11,
  parameter int VCNT_W = 10
) (
  input  logic              clk_48,
  input  logic              reset,
  input  logic [IN_W-1:0]   r_in,
  input  logic [IN_W-1:0]   g_in,
  input  logic [IN_W-1:0]   b_in,
  input  logic              hsync_in,
  input  logic              vsync_in,
  input  logic              display_enable_n,
  output logic              ce_pix,
  output logic [7:0]        VGA_R,
  output logic [7:0]        VGA_G,
  output logic [7:0]        VGA_B,
  output logic              VGA_HS,
  output logic              VGA_VS,
  output logic              VGA_DE,
  output logic              frame_done,
  output logic [15:0]       frame_count,
  output logic [HCNT_W-1:0] h_total,
  output logic [HCNT_W-1:0] h_active,
  output logic [VCNT_W-1:0] v_total,
  output logic [VCNT_W-1:0] v_active
);

  localparam int DIV_W = $clog2(CE_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CE_DIV - 1);

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic             ce_pix_q;
  logic [7:0]       vga_r_q, vga_g_q, vga_b_q;
  logic             hs_q, vs_q, de_q;
  logic             de_s;

  // Replicating the MSBs into the LSBs keeps full-scale input at 8'hFF.
  function automatic logic [7:0] expand(input logic [IN_W-1:0] c);
    return 8'({c, c} >> (2 * IN_W - 8));
  endfunction

  assign de_s = ~display_enable_n;

  always_comb begin
    div_cnt_d = div_cnt_q + 1'b1;
    if (div_cnt_q == DIV_LAST) div_cnt_d = '0;
  end

  always_ff @(posedge clk_48) begin
    if (reset) begin
      div_cnt_q <= '0;
      ce_pix_q  <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      ce_pix_q  <= (div_cnt_q == DIV_LAST);
    end
  end

  // hs_q/vs_q double as the previous-sample syncs for edge detection.
  always_ff @(posedge clk_48) begin
    if (reset) begin
      vga_r_q <= 8'h00;
      vga_g_q <= 8'h00;
      vga_b_q <= 8'h00;
      hs_q    <= 1'b0;
      vs_q    <= 1'b0;
      de_q    <= 1'b0;
    end else if (ce_pix_q) begin
      vga_r_q <= de_s ? expand(r_in) : 8'h00;
      vga_g_q <= de_s ? expand(g_in) : 8'h00;
      vga_b_q <= de_s ? expand(b_in) : 8'h00;
      hs_q    <= hsync_in;
      vs_q    <= vsync_in;
      de_q    <= de_s;
    end
  end

  assign ce_pix = ce_pix_q;
  assign VGA_R  = vga_r_q;
  assign VGA_G  = vga_g_q;
  assign VGA_B  = vga_b_q;
  assign VGA_HS = hs_q;
  assign VGA_VS = vs_q;
  assign VGA_DE = de_q;

`ifdef SIM_VIDEO_STATS_EN
  logic              hs_rise, vs_rise, line_qual;
  logic [HCNT_W-1:0] hcnt_q, hact_q, h_total_q, h_active_q;
  logic [VCNT_W-1:0] vcnt_q, vact_q, v_total_q, v_active_q;
  logic [VCNT_W-1:0] vcnt_d, vact_d;
  logic              h_armed_q, v_armed_q, frame_done_q;
  logic [15:0]       frame_count_q;

  assign hs_rise   = ce_pix_q & hsync_in & ~hs_q;
  assign vs_rise   = ce_pix_q & vsync_in & ~vs_q;
  assign line_qual = (hact_q != '0);

  // Line closes before the frame, so a coincident line is counted into the closing frame.
  always_comb begin
    vcnt_d = vcnt_q;
    vact_d = vact_q;
    if (hs_rise) begin
      vcnt_d = vcnt_q + 1'b1;
      if (line_qual) vact_d = vact_q + 1'b1;
    end
  end

  always_ff @(posedge clk_48) begin
    if (reset) begin
      hcnt_q        <= '0;
      hact_q        <= '0;
      h_total_q     <= '0;
      h_active_q    <= '0;
      vcnt_q        <= '0;
      vact_q        <= '0;
      v_total_q     <= '0;
      v_active_q    <= '0;
      h_armed_q     <= 1'b0;
      v_armed_q     <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_count_q <= '0;
    end else begin
      frame_done_q <= 1'b0;
      if (ce_pix_q) begin
        if (hs_rise) begin
          hcnt_q    <= '0;
          hact_q    <= '0;
          h_armed_q <= 1'b1;
          if (h_armed_q) begin
            h_total_q <= hcnt_q + 1'b1;
            if (line_qual) h_active_q <= hact_q;
          end
        end else begin
          if (hcnt_q != '1) hcnt_q <= hcnt_q + 1'b1;
          if (de_s && hact_q != '1) hact_q <= hact_q + 1'b1;
        end
        // Counters clear on every vsync rise so the first armed frame is measured cleanly.
        if (vs_rise) begin
          vcnt_q        <= '0;
          vact_q        <= '0;
          v_armed_q     <= 1'b1;
          frame_done_q  <= 1'b1;
          frame_count_q <= frame_count_q + 1'b1;
          if (v_armed_q) begin
            v_total_q  <= vcnt_q + 1'b1;
            v_active_q <= vact_d;
          end
        end else begin
          vcnt_q <= vcnt_d;
          vact_q <= vact_d;
        end
      end
    end
  end

  assign frame_done  = frame_done_q;
  assign frame_count = frame_count_q;
  assign h_total     = h_total_q;
  assign h_active    = h_active_q;
  assign v_total     = v_total_q;
  assign v_active    = v_active_q;
`else
  assign frame_done  = 1'b0;
  assign frame_count = '0;
  assign h_total     = '0;
  assign h_active    = '0;
  assign v_total     = '0;
  assign v_active    = '0;
`endif

endmodule

// File: tb/tb_sim_video_out.sv
// Scoreboard bench for sim_video_out: randomized line/frame geometry, expected pixels and
// statistics derived from the generated geometry; a monitor pops and compares each output pixel.
module tb_sim_video_out;
  localparam int IN_W   = 6;
  localparam int CE_DIV = 4;
  localparam int HCNT_W = 11;
  localparam int VCNT_W = 10;
`ifdef SIM_VIDEO_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic              clk_48 = 1'b0;
  logic              reset = 1'b1;
  logic [IN_W-1:0]   r_in = '0, g_in = '0, b_in = '0;
  logic              hsync_in = 1'b0, vsync_in = 1'b0, display_enable_n = 1'b1;
  logic              ce_pix;
  logic [7:0]        VGA_R, VGA_G, VGA_B;
  logic              VGA_HS, VGA_VS, VGA_DE, frame_done;
  logic [15:0]       frame_count;
  logic [HCNT_W-1:0] h_total, h_active;
  logic [VCNT_W-1:0] v_total, v_active;

  sim_video_out #(.IN_W(IN_W), .CE_DIV(CE_DIV), .HCNT_W(HCNT_W), .VCNT_W(VCNT_W)) dut (
    .clk_48(clk_48), .reset(reset), .r_in(r_in), .g_in(g_in), .b_in(b_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .display_enable_n(display_enable_n),
    .ce_pix(ce_pix), .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
    .VGA_HS(VGA_HS), .VGA_VS(VGA_VS), .VGA_DE(VGA_DE), .frame_done(frame_done),
    .frame_count(frame_count), .h_total(h_total), .h_active(h_active),
    .v_total(v_total), .v_active(v_active)
  );

  always #5 clk_48 = ~clk_48;

  typedef struct {
    logic [7:0]  r, g, b;
    logic        hs, vs, de, fd;
    logic [15:0] fc;
    int          ht, ha, vt, va;
  } exp_t;

  exp_t q[$];
  exp_t m_e;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expansion written arithmetically: shift the value to the top, fill with its own MSBs.
  function automatic logic [7:0] exp_col(input int c);
    int v;
    v = (c << (8 - IN_W)) | (c >> (2 * IN_W - 8));
    return v[7:0];
  endfunction

  // Pixel-enable timing: first pulse CE_DIV edges after reset release, then every CE_DIV.
  int k = 0;
  always @(posedge clk_48) k = reset ? 0 : k + 1;

  always @(negedge clk_48) begin
    chk("ce_pix", ce_pix, (k >= CE_DIV && k % CE_DIV == 0));
    if (k >= 1 && k <= CE_DIV) begin
      chk("pre_ce_rgb", {VGA_R, VGA_G, VGA_B}, 0);
      chk("pre_ce_sync", {VGA_HS, VGA_VS, VGA_DE, frame_done}, 0);
      chk("pre_ce_stats", {h_total, h_active, v_total, v_active, frame_count}, 0);
    end
  end

  bit pending = 1'b0;
  always @(negedge clk_48) begin
    if (pending && q.size() > 0) begin
      m_e = q.pop_front();
      chk("vga_r", VGA_R, m_e.r);
      chk("vga_g", VGA_G, m_e.g);
      chk("vga_b", VGA_B, m_e.b);
      chk("vga_sync", {VGA_HS, VGA_VS, VGA_DE}, {m_e.hs, m_e.vs, m_e.de});
      chk("frame_done", frame_done, m_e.fd);
      chk("frame_count", frame_count, m_e.fc);
      chk("h_total", h_total, m_e.ht);
      chk("h_active", h_active, m_e.ha);
      chk("v_total", v_total, m_e.vt);
      chk("v_active", v_active, m_e.va);
    end else begin
      chk("frame_done_idle", frame_done, 0);
    end
    pending = (ce_pix === 1'b1) && !reset;
  end

  // Geometry of the current segment and expected statistics since last reset.
  int g_n, g_hsw, g_a0, g_alen, g_l, g_vsw, g_la0, g_lalen;
  int eh_t, eh_a, ev_t, ev_a, fc;
  bit force_2b = 1'b0;

  task automatic model_reset();
    eh_t = 0; eh_a = 0; ev_t = 0; ev_a = 0; fc = 0;
  endtask

  task automatic wait_ce();
    int n = 0;
    @(negedge clk_48);
    while (ce_pix !== 1'b1) begin
      n++;
      if (n > 4 * CE_DIV) begin
        checks++;
        errors++;
        $display("FAIL ce_timeout: no ce_pix within %0d cycles", 4 * CE_DIV);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
      end
      @(negedge clk_48);
    end
  endtask

  task automatic garbage_inputs();
    hsync_in = 1'b0;
    vsync_in = 1'b0;
    display_enable_n = 1'b0;
    r_in = IN_W'($urandom);
    g_in = IN_W'($urandom);
    b_in = IN_W'($urandom);
  endtask

  task automatic do_reset();
    @(negedge clk_48);
    reset = 1'b1;
    garbage_inputs();
    repeat (2) @(negedge clk_48);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic random_geometry();
    g_n    = $urandom_range(40, 16);
    g_hsw  = $urandom_range(3, 1);
    g_a0   = g_hsw + $urandom_range(2, 0);
    g_alen = $urandom_range(g_n - g_a0 - 1, 1);
    g_l    = $urandom_range(12, 6);
    g_vsw  = $urandom_range(2, 1);
    g_la0  = $urandom_range(2, 1);
    g_lalen = $urandom_range(g_l - g_la0 - 1, 1);
  endtask

  function automatic bit line_is_active(input int l);
    return (l >= g_la0) && (l < g_la0 + g_lalen);
  endfunction

  task automatic run_seg(input int frames, input int stop_f, input int stop_l, input int stop_s);
    exp_t e;
    int   rr, gg, bb, prev_l;
    bit   hs, vs, de, fd;
    for (int f = 0; f < frames; f++) begin
      for (int l = 0; l < g_l; l++) begin
        for (int s = 0; s < g_n; s++) begin
          if (f == stop_f && l == stop_l && s == stop_s) return;
          hs = (s < g_hsw);
          vs = (l < g_vsw);
          de = line_is_active(l) && (s >= g_a0) && (s < g_a0 + g_alen);
          rr = $urandom_range((1 << IN_W) - 1, 0);
          gg = $urandom_range((1 << IN_W) - 1, 0);
          bb = $urandom_range((1 << IN_W) - 1, 0);
          if (de && force_2b) begin
            rr = 'h2B;
            force_2b = 1'b0;
          end
          if (s == 0 && !(f == 0 && l == 0)) begin
            eh_t   = g_n;
            prev_l = (l == 0) ? g_l - 1 : l - 1;
            if (line_is_active(prev_l)) eh_a = g_alen;
          end
          fd = (s == 0 && l == 0);
          if (fd) begin
            if (f > 0) begin
              ev_t = g_l;
              ev_a = g_lalen;
            end
            fc = (fc + 1) & 'hFFFF;
          end
          wait_ce();
          r_in = IN_W'(rr);
          g_in = IN_W'(gg);
          b_in = IN_W'(bb);
          hsync_in = hs;
          vsync_in = vs;
          display_enable_n = ~de;
          e.r  = de ? exp_col(rr) : 8'h00;
          e.g  = de ? exp_col(gg) : 8'h00;
          e.b  = de ? exp_col(bb) : 8'h00;
          e.hs = hs;
          e.vs = vs;
          e.de = de;
          e.fd = STATS ? fd : 1'b0;
          e.fc = STATS ? 16'(fc) : 16'h0;
          e.ht = STATS ? eh_t : 0;
          e.ha = STATS ? eh_a : 0;
          e.vt = STATS ? ev_t : 0;
          e.va = STATS ? ev_a : 0;
          q.push_back(e);
        end
      end
    end
  endtask

  initial begin
    model_reset();
    repeat (3) @(negedge clk_48);
    reset = 1'b0;
    garbage_inputs();

    // Random geometry, three frames; first active pixel carries r = 6'h2B.
    random_geometry();
    force_2b = 1'b1;
    run_seg(3, -1, -1, -1);

    // Fixed 800-sample lines with 640 active samples.
    do_reset();
    g_n = 800; g_hsw = 96; g_a0 = 144; g_alen = 640;
    g_l = 3; g_vsw = 1; g_la0 = 0; g_lalen = 3;
    run_seg(1, -1, -1, -1);

    // Stop mid-line in the second frame and reset with statistics valid.
    do_reset();
    random_geometry();
    run_seg(2, 1, 3, g_n / 2);
    repeat (3 * CE_DIV) @(negedge clk_48);
    reset = 1'b1;
    @(negedge clk_48);
    chk("rst_h_stats", {h_total, h_active}, 0);
    chk("rst_v_stats", {v_total, v_active}, 0);
    chk("rst_frame", {frame_count, frame_done}, 0);
    chk("rst_video", {VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, VGA_DE}, 0);
    @(negedge clk_48);
    reset = 1'b0;
    model_reset();
    garbage_inputs();

    // After reset the first hsync/vsync rises must latch nothing.
    random_geometry();
    run_seg(2, -1, -1, -1);

    repeat (3 * CE_DIV) @(negedge clk_48);
    chk("queue_drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    checks++;
    errors++;
    $display("FAIL watchdog: run did not complete in time");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
